// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding, parity
// selectors and the supported oversampling ratios.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    function automatic logic prescale_legal(input int value);
        return (value == PRESCALE_8) || (value == PRESCALE_16) || (value == PRESCALE_32);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling counter and bit sampler for uart_rx_ctrl.
// UART_RX_MAJORITY_EN selects a 2-of-3 vote around mid-bit instead of a single sample.
module uart_rx_sampler #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  active_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    input  logic                  rx_i,
    output logic                  sampled_bit_o,
    output logic                  bit_done_o
);

    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] edge_cnt_q;
    logic [PRESCALE_W-1:0] edge_cnt_d;
    logic [PRESCALE_W-1:0] last_edge_s;
    logic [PRESCALE_W-1:0] mid_edge_s;

    assign last_edge_s = prescale_i - ONE;
    assign mid_edge_s  = prescale_i >> 1;
    assign bit_done_o  = active_i && (edge_cnt_q == last_edge_s);

    // Edge counter wraps at the end of every bit and parks at zero when idle
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        if (!active_i) begin
            edge_cnt_d = '0;
        end else if (bit_done_o) begin
            edge_cnt_d = '0;
        end else begin
            edge_cnt_d = edge_cnt_q + ONE;
        end
    end

    // Edge counter register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            edge_cnt_q <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [2:0] smp_q;
    logic [2:0] smp_d;

    // Capture three samples straddling mid-bit; the vote is ready well before bit end
    always_comb begin
        smp_d = smp_q;
        if (active_i && (edge_cnt_q == (mid_edge_s - ONE))) begin
            smp_d[0] = rx_i;
        end else if (active_i && (edge_cnt_q == mid_edge_s)) begin
            smp_d[1] = rx_i;
        end else if (active_i && (edge_cnt_q == (mid_edge_s + ONE))) begin
            smp_d[2] = rx_i;
        end else begin
            smp_d = smp_q;
        end
    end

    // Sample registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            smp_q <= 3'b111;
        end else begin
            smp_q <= smp_d;
        end
    end

    assign sampled_bit_o = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
`else
    logic smp_q;
    logic smp_d;

    // Single mid-bit sample
    always_comb begin
        smp_d = smp_q;
        if (active_i && (edge_cnt_q == mid_edge_s)) begin
            smp_d = rx_i;
        end else begin
            smp_d = smp_q;
        end
    end

    // Sample register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            smp_q <= 1'b1;
        end else begin
            smp_q <= smp_d;
        end
    end

    assign sampled_bit_o = smp_q;
`endif

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver controller: start validation, LSB-first deserialization,
// optional parity and stop checking. Sampling mode set by UART_RX_MAJORITY_EN.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_W-1:0] PRESCALE_DEFAULT = PRESCALE_W'(PRESCALE_8);

    rx_state_e             state_q, state_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_mis_q, par_mis_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;

    logic active_s;
    logic sampled_bit_s;
    logic bit_done_s;

    function automatic logic expected_parity(input logic [DATA_WIDTH-1:0] data, input logic typ);
        logic result;
        case (typ)
            PAR_EVEN: result = ^data;
            PAR_ODD:  result = ~^data;
            default:  result = ^data;
        endcase
        return result;
    endfunction

    // The detection cycle already counts as edge 0 of the start bit
    assign active_s = (state_q != IDLE) || !RX_IN;

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .clk_i         (CLK),
        .rst_ni        (RST),
        .active_i      (active_s),
        .prescale_i    (prescale_q),
        .rx_i          (RX_IN),
        .sampled_bit_o (sampled_bit_s),
        .bit_done_o    (bit_done_s)
    );

    // Next-state, datapath and output pulse logic
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_mis_d    = par_mis_q;
        prescale_d   = prescale_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!RX_IN) begin
                    state_d    = START;
                    bit_cnt_d  = '0;
                    par_mis_d  = 1'b0;
                    prescale_d = prescale_legal(int'(Prescale)) ? Prescale : PRESCALE_DEFAULT;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (bit_done_s) begin
                    state_d = sampled_bit_s ? IDLE : DATA;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (bit_done_s) begin
                    shift_d = {sampled_bit_s, shift_q[DATA_WIDTH-1:1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end else begin
                    state_d = DATA;
                end
            end
            PARITY: begin
                if (bit_done_s) begin
                    par_mis_d = (sampled_bit_s != expected_parity(shift_q, par_typ_q));
                    state_d   = STOP;
                end else begin
                    state_d = PARITY;
                end
            end
            STOP: begin
                if (bit_done_s) begin
                    state_d = IDLE;
                    if (!sampled_bit_s) begin
                        stp_err_d = 1'b1;
                    end else if (par_mis_q) begin
                        par_err_d = 1'b1;
                    end else begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_mis_q    <= 1'b0;
            prescale_q   <= PRESCALE_DEFAULT;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_mis_q    <= par_mis_d;
            prescale_q   <= prescale_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign DATA_VALID = data_valid_q;
    assign PAR_ERR    = par_err_q;
    assign STP_ERR    = stp_err_q;

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
UART receiver controller; the receive-side counterpart to the UART_TX controller FSM in the same UART block.
- Oversamples RX_IN at Prescale clocks per bit.
- Validates the start bit and deserializes data LSB-first.
- Checks the optional parity bit and the stop bit.
- Presents the received word with a one-cycle DATA_VALID pulse, or a one-cycle error pulse.
- Sits between the pad-side synchronizer and the RX data consumer.

Parameters:
DATA_WIDTH, 8, number of data bits per frame.
PRESCALE_W, 6, width of the Prescale input.

Ports:
CLK  input  1  system clock; all logic on its rising edge.
RST  input  1  synchronous active-low reset.
RX_IN  input  1  serial line, already synchronized; idle high.
PAR_EN  input  1  1 = frame carries a parity bit.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
Prescale  input  PRESCALE_W  clocks per bit; legal values 8, 16, 32.
P_DATA  output  DATA_WIDTH  last good received word.
DATA_VALID  output  1  one-cycle pulse: P_DATA updated.
PAR_ERR  output  1  one-cycle pulse: parity mismatch, frame dropped.
STP_ERR  output  1  one-cycle pulse: stop bit sampled low, frame dropped.

Behaviour:
- Reset: one clock, synchronous active-low, as decided. While RST=0 at a CLK edge: state=IDLE, counters=0, P_DATA=0, DATA_VALID=0, PAR_ERR=0, STP_ERR=0. Reset mid-frame aborts the frame silently; no pulses.
- Configuration latch: Prescale, PAR_EN and PAR_TYP are latched on start detection. Changes mid-frame are ignored.
- Counters:
  - edge_cnt runs 0..Prescale-1 within each bit.
  - bit_cnt runs 0..DATA_WIDTH-1 in DATA.
  - The start-detection cycle is edge_cnt=0 of the start bit.
- Sampling: the bit value is taken at edge_cnt = Prescale/2 (base behaviour).
- States:
  - IDLE: outputs idle. RX_IN=0 -> START.
  - START: at edge_cnt=Prescale-1, sampled bit 1 (glitch) -> IDLE with no pulse; else -> DATA.
  - DATA: the sampled bit is shifted into the shift register LSB-first. At the end of bit DATA_WIDTH-1 -> PARITY if PAR_EN, else STOP.
  - PARITY: computes expected parity over the shift register; even: XOR; odd: ~XOR. Records a mismatch flag. -> STOP at end of bit.
  - STOP: at edge_cnt=Prescale-1 the frame is evaluated:
    - stop sampled 0: STP_ERR=1.
    - otherwise, parity mismatch: PAR_ERR=1.
    - otherwise: P_DATA<=shift register, DATA_VALID=1.
    - Then -> IDLE.
- Error priority: STP_ERR takes precedence; only one pulse per frame. P_DATA is unchanged on error.
- Pulse timing: pulses are registered and visible exactly at cycle N*Prescale after detection, where N = 2 + DATA_WIDTH + PAR_EN. They stay high for exactly one cycle.
- Back-to-back frames: IDLE accepts RX_IN=0 in the cycle the pulse is visible. Zero idle cycles between frames is legal.
- Illegal Prescale (not 8/16/32): behaviour is undefined. The verifier constrains stimulus to legal values.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: three samples at edge_cnt Prescale/2-1, Prescale/2 and Prescale/2+1; the bit value is the majority (2 of 3). Decisions still take effect at edge_cnt=Prescale-1, so frame latency is unchanged.
- Undefined: single sample at edge_cnt=Prescale/2.

Decomposition:
- Package uart_rx_pkg holds:
  - state encoding constants IDLE/START/DATA/PARITY/STOP (3-bit);
  - PAR_EVEN=0, PAR_ODD=1;
  - the legal prescale constants 8/16/32.
- One sub-module, uart_rx_sampler, holds edge_cnt, the sample strobes and the majority logic (macro-dependent). It outputs sampled_bit and bit_done.
- The FSM, bit_cnt, shift register, parity check and output registers stay in uart_rx_ctrl.

Test Plan:
- Good frame: Prescale=8, PAR_EN=1, PAR_TYP=0, byte 0xA5 with parity 0 -> P_DATA=0xA5; DATA_VALID high for 1 cycle at cycle 88; no errors.
- Odd parity wrong: Prescale=16, PAR_TYP=1, byte 0x3C with parity bit 0 -> PAR_ERR 1-cycle pulse at cycle 176; P_DATA keeps its previous value; DATA_VALID=0.
- Framing error: Prescale=8, PAR_EN=0, byte 0x5A with stop bit 0 -> STP_ERR pulse at cycle 80; then RX_IN returns high with no spurious frame reported. A subsequent low is treated as a new start bit.
- Start glitch: Prescale=16, RX_IN low for 3 cycles then high -> IDLE after 16 cycles; no pulses. A following good 0x81 frame is received correctly.
- Back-to-back: Prescale=32, PAR_EN=0, frames 0x00 then 0xFF with zero idle cycles -> DATA_VALID at cycle 320 (P_DATA=0x00) and cycle 640 (P_DATA=0xFF).
- Reset mid-frame: RST=0 for 1 cycle during bit 4 of a frame -> all outputs 0 next cycle; no pulse. With UART_RX_MAJORITY_EN, a single-cycle inverted glitch at the Prescale/2 sample of each data bit still yields 0xA5.
